// File: rtl/store_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_align_unit
// Brief    : Narrows and lane-positions a 32-bit store operand into
//            word-aligned write beats with byte enables. A store that
//            crosses a word boundary is issued as two beats, or rejected,
//            depending on ALLOW_MISALIGNED.
// Revision : 1.0 - initial release
// ============================================================================
module store_align_unit #(
    parameter int ADDR_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0]           in_wdata,
    input  logic [1:0]            in_size,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_word_step = ADDR_WIDTH'(4);

    state_t r_state;

    // Beat-1 values captured at acceptance so later input changes are ignored.
    logic                  r_split;
    logic [ADDR_WIDTH-1:0] r_b1_addr;
    logic [31:0]           r_b1_wdata;
    logic [3:0]            r_b1_be;

    logic [1:0]            w_off;
    logic [31:0]           w_data_masked;
    logic [3:0]            w_be_base;
    logic [63:0]           w_data_wide;
    logic [7:0]            w_be_wide;
    logic                  w_split;
    logic                  w_illegal_size;
    logic                  w_reject_split;
    logic                  w_reject;
    logic [ADDR_WIDTH-1:0] w_base_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    assign w_off = in_addr[1:0];

    // Keep only the bytes the access size uses, and the matching lane mask.
    always_comb begin
        w_data_masked = 32'h0;
        w_be_base     = 4'b0000;
        case (in_size)
            2'b00: begin
                w_data_masked = {24'h0, in_wdata[7:0]};
                w_be_base     = 4'b0001;
            end
            2'b01: begin
                w_data_masked = {16'h0, in_wdata[15:0]};
                w_be_base     = 4'b0011;
            end
            2'b10: begin
                w_data_masked = in_wdata;
                w_be_base     = 4'b1111;
            end
            default: begin
                w_data_masked = 32'h0;
                w_be_base     = 4'b0000;
            end
        endcase
    end

    // Shifting into a two-word window gives both beats at once: the low
    // word is beat 0, the high word is whatever spilled into the next word.
    assign w_data_wide    = {32'h0, w_data_masked} << {w_off, 3'b000};
    assign w_be_wide      = {4'b0000, w_be_base} << w_off;
    assign w_split        = |w_be_wide[7:4];
    assign w_illegal_size = (in_size == 2'b11);

    generate
        if (ALLOW_MISALIGNED) begin : g_split_allowed
            assign w_reject_split = 1'b0;
        end else begin : g_split_rejected
            assign w_reject_split = w_split;
        end
    endgenerate

    assign w_reject    = w_illegal_size | w_reject_split;
    assign w_base_addr = {in_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_next_addr = w_base_addr + c_word_step;

    // Sequencer: accept in IDLE, hold each beat until acked, pulse done/err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            in_ready   <= 1'b1;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'b0000;
            done       <= 1'b0;
            err        <= 1'b0;
            r_split    <= 1'b0;
            r_b1_addr  <= '0;
            r_b1_wdata <= 32'h0;
            r_b1_be    <= 4'b0000;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        if (w_reject) begin
                            err <= 1'b1;
                        end else begin
                            r_state    <= ST_BEAT0;
                            in_ready   <= 1'b0;
                            mem_req    <= 1'b1;
                            mem_addr   <= w_base_addr;
                            mem_wdata  <= w_data_wide[31:0];
                            mem_be     <= w_be_wide[3:0];
                            r_split    <= w_split;
                            r_b1_addr  <= w_next_addr;
                            r_b1_wdata <= w_data_wide[63:32];
                            r_b1_be    <= w_be_wide[7:4];
                        end
                    end
                end
                ST_BEAT0: begin
                    if (mem_ack) begin
                        if (r_split) begin
                            r_state   <= ST_BEAT1;
                            mem_addr  <= r_b1_addr;
                            mem_wdata <= r_b1_wdata;
                            mem_be    <= r_b1_be;
                        end else begin
                            r_state   <= ST_IDLE;
                            in_ready  <= 1'b1;
                            mem_req   <= 1'b0;
                            mem_be    <= 4'b0000;
                            mem_wdata <= 32'h0;
                            done      <= 1'b1;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (mem_ack) begin
                        r_state   <= ST_IDLE;
                        in_ready  <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    in_ready <= 1'b1;
                    mem_req  <= 1'b0;
                    mem_be   <= 4'b0000;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
